serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_pkg.sv | 20 ++
 rtl/bit_timer.sv | 32 +++
 rtl/serial_word_tx.sv | 97 +++++++++
 tb/tb_serial_word_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and widths for the serial word transmitter.
package serial_pkg;

   localparam int unsigned CFG_W = 3;
   localparam int unsigned RES_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // One step of a running mod-7 remainder: (2*res + b) mod 7, with res already < 7.
   function automatic logic [RES_W-1:0] mod7_step(input logic [RES_W-1:0] res, input logic b);
      logic [RES_W:0] t;
      t = {res, b};
      return (t >= (RES_W+1)'(7)) ? RES_W'(t - (RES_W+1)'(7)) : RES_W'(t);
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit period timer: latches the period select on accept and marks the last hold cycle of each bit.
module bit_timer
   import serial_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             active,
   input  logic [CFG_W-1:0] configure,
   output logic             bit_strobe
);

   logic [CFG_W-1:0] cfg_q;
   logic [CFG_W-1:0] tick_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q    <= '0;
         tick_cnt <= '0;
      end else if (start) begin
         cfg_q    <= configure;
         tick_cnt <= '0;
      end else if (enable && active) begin
         tick_cnt <= (tick_cnt == cfg_q) ? '0 : tick_cnt + CFG_W'(1);
      end
   end

   // Reset suppresses the strobe so a frame being discarded never flags a sample point.
   assign bit_strobe = active && enable && !reset && (tick_cnt == cfg_q);

endmodule

// File: rtl/serial_word_tx.sv
// MSB-first serialiser of a WIDTH-bit word with programmable bit period.
// Define MOD7_CHECK_EN to add the running mod-7 residue port.
module serial_word_tx
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CFG_W-1:0] configure,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             bit_strobe,
   output logic             frame_active,
   output logic             done
`ifdef MOD7_CHECK_EN
   ,
   output logic [RES_W-1:0] residue
`endif
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic             accept;
   logic             shifting;

   assign shifting = (state == SHIFT);
   assign accept   = (state == IDLE) && load_valid && enable;

   bit_timer u_bit_timer (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start      (accept),
      .active     (shifting),
      .configure  (configure),
      .bit_strobe (bit_strobe)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else if (enable) begin
         unique case (state)
            IDLE: begin
               if (load_valid) begin
                  shift_reg <= data_in;
                  bit_cnt   <= CNT_W'(WIDTH - 1);
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_strobe) begin
                  shift_reg <= shift_reg << 1;
                  bit_cnt   <= bit_cnt - CNT_W'(1);
                  if (bit_cnt == '0) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign load_ready   = (state == IDLE);
   assign frame_active = shifting;
   assign serial_out   = shifting && shift_reg[WIDTH-1];
   assign done         = (state == DONE) && enable && !reset;

`ifdef MOD7_CHECK_EN
   // Residue tracks the value of the bits already on the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         residue <= '0;
      end else if (accept) begin
         residue <= '0;
      end else if (bit_strobe) begin
         residue <= mod7_step(residue, shift_reg[WIDTH-1]);
      end
   end
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: vector table of whole frames plus reset and back-to-back sequences.
module tb_serial_word_tx;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [2:0]  configure;
   logic [31:0] data_in;
   logic        load_valid;
   logic        load_ready;
   logic        serial_out;
   logic        bit_strobe;
   logic        frame_active;
   logic        done;
`ifdef MOD7_CHECK_EN
   logic [2:0]  residue;
`endif

   int total = 0;
   int bad   = 0;

   serial_word_tx #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .configure    (configure),
      .data_in      (data_in),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .serial_out   (serial_out),
      .bit_strobe   (bit_strobe),
      .frame_active (frame_active),
      .done         (done)
`ifdef MOD7_CHECK_EN
      ,
      .residue      (residue)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  cfg;
      logic [2:0]  cfg_late;
      int          stall_at;
      int          stall_len;
      int          exp_cycles;
      logic [2:0]  exp_res;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full frame: accept, per-cycle bit/strobe model, done timing and residue.
   task automatic run_vec(input vec_t v);
      int   k;
      int   cyc;
      int   per;
      logic exp_bit;
      logic exp_stb;
      per        = int'(v.cfg) + 1;
      configure  = v.cfg;
      data_in    = v.data;
      load_valid = 1'b1;
      enable     = 1'b1;
      #1;
      chk("ready_idle", 32'(load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
      configure  = v.cfg_late;
      data_in    = ~v.data;
      k   = 0;
      cyc = 0;
      while (k < 32 * per && cyc < 1000) begin
         enable = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
         #1;
         exp_bit = v.data[31 - k / per];
         exp_stb = enable && ((k % per) == per - 1);
         chk("serial_out", 32'(serial_out), 32'(exp_bit));
         chk("bit_strobe", 32'(bit_strobe), 32'(exp_stb));
         chk("frame_active", 32'(frame_active), 32'd1);
         chk("done_early", 32'(done), 32'd0);
         tick();
         if (enable) k++;
         cyc++;
      end
      enable = 1'b1;
      #1;
      chk("frame_cycles", 32'(cyc), 32'(v.exp_cycles));
      chk("done_pulse", 32'(done), 32'd1);
      chk("serial_done", 32'(serial_out), 32'd0);
      chk("active_done", 32'(frame_active), 32'd0);
      chk("ready_done", 32'(load_ready), 32'd0);
`ifdef MOD7_CHECK_EN
      chk("residue_done", 32'(residue), 32'(v.exp_res));
`endif
      tick();
      #1;
      chk("ready_after", 32'(load_ready), 32'd1);
      chk("done_after", 32'(done), 32'd0);
`ifdef MOD7_CHECK_EN
      chk("residue_hold", 32'(residue), 32'(v.exp_res));
`endif
   endtask

   initial begin
      logic [31:0] a_word;
      int n;

      vecs[0] = '{32'h8000_0001, 3'd0, 3'd0,  0, 0,  32, 3'd3};
      vecs[1] = '{32'h0000_000A, 3'd3, 3'd3,  0, 0, 128, 3'd3};
      vecs[2] = '{32'hFFFF_FFFF, 3'd0, 3'd0, 10, 5,  37, 3'd3};
      vecs[3] = '{32'h1234_5678, 3'd0, 3'd7,  0, 0,  32, 3'd5};
      vecs[4] = '{32'h0000_FFFF, 3'd1, 3'd5,  3, 2,  66, 3'd1};

      reset      = 1'b1;
      enable     = 1'b1;
      configure  = 3'd0;
      data_in    = 32'h0;
      load_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_serial", 32'(serial_out), 32'd0);
      chk("rst_active", 32'(frame_active), 32'd0);
      chk("rst_strobe", 32'(bit_strobe), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
`ifdef MOD7_CHECK_EN
      chk("rst_residue", 32'(residue), 32'd0);
`endif

      // Offer with enable low must not be accepted.
      enable     = 1'b0;
      load_valid = 1'b1;
      data_in    = 32'hDEAD_BEEF;
      tick();
      enable     = 1'b1;
      load_valid = 1'b0;
      #1;
      chk("no_accept_disabled", 32'(load_ready), 32'd1);

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Reset at bit 10 discards the frame.
      configure  = 3'd0;
      data_in    = 32'hFFFF_FFFF;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      #1;
      chk("pre_rst_active", 32'(frame_active), 32'd1);
      reset      = 1'b1;
      load_valid = 1'b1;
      #1;
      chk("rst_strobe_gate", 32'(bit_strobe), 32'd0);
      tick();
      reset      = 1'b0;
      load_valid = 1'b0;
      #1;
      chk("midrst_serial", 32'(serial_out), 32'd0);
      chk("midrst_active", 32'(frame_active), 32'd0);
      chk("midrst_ready", 32'(load_ready), 32'd1);
`ifdef MOD7_CHECK_EN
      chk("midrst_residue", 32'(residue), 32'd0);
`endif
      tick();

      // Back-to-back words with load_valid held high.
      a_word     = 32'h8000_0001;
      data_in    = a_word;
      configure  = 3'd0;
      load_valid = 1'b1;
      enable     = 1'b1;
      tick();
      data_in = 32'hC000_0000;
      for (int k = 0; k < 32; k++) begin
         #1;
         chk("b2b_a_bit", 32'(serial_out), 32'(a_word[31 - k]));
         tick();
      end
      #1;
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_done_ready", 32'(load_ready), 32'd0);
      tick();
      #1;
      chk("b2b_idle_ready", 32'(load_ready), 32'd1);
      chk("b2b_idle_active", 32'(frame_active), 32'd0);
      tick();
      load_valid = 1'b0;
      #1;
      chk("b2b_b_active", 32'(frame_active), 32'd1);
      chk("b2b_b_msb", 32'(serial_out), 32'd1);
      n = 0;
      while (!done && n < 200) begin
         tick();
         #1;
         n++;
      end
      chk("b2b_b_cycles", 32'(n), 32'd32);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
